// File: rtl/add_16bit_signed_serial_if.sv
// ---------------------------------------------------------------------------
// add_16bit_signed_serial_if
// Request/response bundle of the digit-serial 16-bit signed adder.
//   start    : request strobe, only honoured while the adder is idle
//   A, B     : signed operands, captured on the accepted start edge
//   busy     : high while digits are being processed
//   done     : one-cycle completion pulse
//   result   : signed sum (wrapped or clamped), held until next completion
//   overflow : signed overflow flag of the last completed operation
// master drives the request side, slave is the adder itself.
// ---------------------------------------------------------------------------
interface add_16bit_signed_serial_if;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        overflow;

    modport master (
        output start, A, B,
        input  busy, done, result, overflow
    );

    modport slave (
        input  start, A, B,
        output busy, done, result, overflow
    );
endinterface

// File: rtl/add_16bit_signed_serial.sv
// ---------------------------------------------------------------------------
// add_16bit_signed_serial
// Digit-serial 16-bit two's-complement adder. Operands are latched on an
// accepted start, added DIGIT_W bits per cycle through a registered ripple
// carry, and the sum plus signed overflow is published with a done pulse.
//   DIGIT_W  : bits per cycle (1, 2, 4, 8 or 16); N = 16/DIGIT_W cycles
//   SATURATE : 1 clamps an overflowed sum to 16'h7FFF / 16'h8000, 0 wraps
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of add_16bit_signed_serial_if
// ---------------------------------------------------------------------------
module add_16bit_signed_serial #(
    parameter int DIGIT_W  = 4,
    parameter int SATURATE = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    add_16bit_signed_serial_if.slave  bus
);

    localparam int N  = 16 / DIGIT_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic          SAT_EN   = (SATURATE != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Signed overflow: operands share a sign and the sum's sign differs.
    function automatic logic ovf_f(input logic a_msb, input logic b_msb,
                                   input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    // Clamp toward the operand sign when saturation is enabled and overflowed.
    function automatic logic [15:0] clamp_f(input logic [15:0] sum,
                                            input logic        ovf,
                                            input logic        a_msb,
                                            input logic        sat);
        return (sat && ovf) ? (a_msb ? 16'h8000 : 16'h7FFF) : sum;
    endfunction

    state_t          state_q, state_d;
    logic [15:0]     a_q, a_d;
    logic [15:0]     b_q, b_d;
    logic [15:0]     sum_q, sum_d;
    logic            carry_q, carry_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     result_q, result_d;
    logic            ovf_q, ovf_d;
    logic            busy_q;
    logic            done_q;

    logic [3:0]         base_s;
    logic [DIGIT_W-1:0] digit_a_s;
    logic [DIGIT_W-1:0] digit_b_s;
    logic [DIGIT_W:0]   digit_sum_s;
    logic [15:0]        sum_full_s;
    logic               ovf_s;

    // Bit offset of the current digit; DIGIT_W=16 truncates to 0 with cnt=0.
    assign base_s      = 4'(cnt_q) * 4'(DIGIT_W);
    assign digit_a_s   = a_q[base_s +: DIGIT_W];
    assign digit_b_s   = b_q[base_s +: DIGIT_W];
    assign digit_sum_s = {1'b0, digit_a_s} + {1'b0, digit_b_s}
                       + {{DIGIT_W{1'b0}}, carry_q};

    // Partial sum with the digit of this cycle merged in; complete on the last digit.
    always_comb begin
        sum_full_s                    = sum_q;
        sum_full_s[base_s +: DIGIT_W] = digit_sum_s[DIGIT_W-1:0];
    end

    assign ovf_s = ovf_f(a_q[15], b_q[15], sum_full_s[15]);

    // Next-state and datapath update for IDLE/RUN/DONE.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    a_d     = bus.A;
                    b_d     = bus.B;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sum_d   = sum_full_s;
                carry_d = digit_sum_s[DIGIT_W];
                if (cnt_q == CNT_LAST) begin
                    // Carry out of bit 15 is dropped; only the sign rule matters.
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    ovf_d    = ovf_s;
                    result_d = clamp_f(sum_full_s, ovf_s, a_q[15], SAT_EN);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, operand, partial-sum and result registers; status flags follow next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            sum_q    <= 16'h0000;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= 16'h0000;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            busy_q   <= (state_d == S_RUN);
            done_q   <= (state_d == S_DONE);
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_add_16bit_signed_serial.sv
// ---------------------------------------------------------------------------
// tb_add_16bit_signed_serial
// Six adder instances (DIGIT_W 1/4/16 x SATURATE 0/1) share one stimulus
// stream. Each instance has its own expectation queue filled at the edge a
// start is accepted and a monitor that pops and compares on every done.
// ---------------------------------------------------------------------------
module tb_add_16bit_signed_serial;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start_s;
    logic [15:0] a_s;
    logic [15:0] b_s;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] corners [9] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000,
                                 16'h7FFE, 16'h8001, 16'h4000, 16'hC000};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input int inst, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %0h, expected %0h (t=%0t)", nm, inst, act, exp, $time);
        end
    endtask

    task automatic fail_now(input int inst, input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s inst%0d (t=%0t)", nm, inst, $time);
    endtask

    // Plain integer arithmetic reference: range check decides overflow.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input bit sat, input int due);
        exp_t e;
        int   s;
        s     = int'($signed(a)) + int'($signed(b));
        e.ovf = (s > 32767) || (s < -32768);
        if (sat && e.ovf) e.res = (s > 0) ? 16'h7FFF : 16'h8000;
        else              e.res = s[15:0];
        e.due = due;
        return e;
    endfunction

    for (genvar g = 0; g < 6; g++) begin : g_dut
        localparam int DW  = (g < 2) ? 1 : ((g < 4) ? 4 : 16);
        localparam bit SAT = (g % 2) == 1;
        localparam int N   = 16 / DW;

        add_16bit_signed_serial_if ifc ();
        assign ifc.start = start_s;
        assign ifc.A     = a_s;
        assign ifc.B     = b_s;

        add_16bit_signed_serial #(
            .DIGIT_W  (DW),
            .SATURATE (SAT ? 1 : 0)
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (ifc)
        );

        exp_t        q [$];
        int          edge_n;
        int          cool;
        int          busy_run;
        logic        prev_done;
        logic [15:0] last_res;
        logic        last_ovf;

        // Acceptance model: a start counts only when the previous op's N+2 edges elapsed.
        initial begin
            edge_n = 0;
            cool   = 0;
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    q.delete();
                    cool = 0;
                end else begin
                    edge_n++;
                    if (cool > 0) begin
                        cool--;
                    end else if (start_s) begin
                        q.push_back(model(a_s, b_s, SAT, edge_n + N));
                        cool = N + 1;
                    end
                end
            end
        end

        // Monitor: compares outputs on the falling edge.
        initial begin
            exp_t e;
            busy_run  = 0;
            prev_done = 1'b0;
            last_res  = 16'h0000;
            last_ovf  = 1'b0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    busy_run  = 0;
                    prev_done = 1'b0;
                    last_res  = 16'h0000;
                    last_ovf  = 1'b0;
                    chk(g, "rst_busy",     32'(ifc.busy),     32'd0);
                    chk(g, "rst_done",     32'(ifc.done),     32'd0);
                    chk(g, "rst_result",   32'(ifc.result),   32'd0);
                    chk(g, "rst_overflow", 32'(ifc.overflow), 32'd0);
                end else begin
                    chk(g, "busy_and_done", 32'(ifc.busy & ifc.done), 32'd0);
                    if (ifc.busy) busy_run++;
                    if (ifc.done) begin
                        chk(g, "done_width", 32'(prev_done), 32'd0);
                        if (q.size() == 0) begin
                            fail_now(g, "unexpected_done");
                        end else begin
                            e = q.pop_front();
                            chk(g, "result",     32'(ifc.result),   32'(e.res));
                            chk(g, "overflow",   32'(ifc.overflow), 32'(e.ovf));
                            chk(g, "done_edge",  32'(edge_n),       32'(e.due));
                            chk(g, "busy_width", 32'(busy_run),     32'(N));
                            last_res = e.res;
                            last_ovf = e.ovf;
                        end
                        busy_run = 0;
                    end else begin
                        chk(g, "held_result",   32'(ifc.result),   32'(last_res));
                        chk(g, "held_overflow", 32'(ifc.overflow), 32'(last_ovf));
                    end
                    prev_done = ifc.done;
                    if (q.size() > 0 && q[0].due < edge_n) begin
                        fail_now(g, "done_missing");
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    // One start strobe, then scramble the operands while the op is in flight.
    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        a_s     = a;
        b_s     = b;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        for (int i = 0; i < 19; i++) begin
            a_s = 16'($urandom);
            b_s = 16'($urandom);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start_s = 1'b0;
        a_s     = 16'h0000;
        b_s     = 16'h0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed boundary cases.
        issue(16'h7FFF, 16'h0001);
        issue(16'h8000, 16'hFFFF);
        issue(16'hFFFF, 16'h0001);
        issue(16'h0064, 16'hFFE2);

        // Start held through RUN with toggling operands; re-launch only from IDLE.
        @(negedge clk);
        a_s     = 16'd100;
        b_s     = 16'hFFE2;
        start_s = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a_s = (i % 2 == 0) ? 16'd5 : 16'($urandom);
            b_s = (i % 2 == 0) ? 16'd5 : 16'($urandom);
        end
        start_s = 1'b0;
        repeat (20) @(negedge clk);

        // Reset in the middle of an operation.
        a_s     = 16'd1234;
        b_s     = 16'd1;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(16'h4000, 16'h4000);

        // Full cross of the corner operands.
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 9; j++) begin
                issue(corners[i], corners[j]);
            end
        end

        // Random traffic with random start density.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            start_s = ($urandom_range(0, 2) == 0);
            a_s = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 8)] : 16'($urandom);
            b_s = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 8)] : 16'($urandom);
        end
        @(negedge clk);
        start_s = 1'b0;
        repeat (25) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
